// File: rtl/dynamic_routing_mac_pipe.sv
// Pipelined multiply / multiply-accumulate with one global stall signal.
// The last stage is both the output register and the group accumulator.
module dynamic_routing_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  is_signed,
    input  logic                  acc_en,
    input  logic                  last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [7:0]            acc_cnt,
    output logic                  ovf
);
    localparam int PW = din0_WIDTH + din1_WIDTH + 2;

    generate
        if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_stage
            $error("NUM_STAGE must be in 1..4");
        end
        if (dout_WIDTH < 2 || dout_WIDTH > 64) begin : g_bad_width
            $error("dout_WIDTH must be in 2..64");
        end
        if (ID < 0) begin : g_bad_id
            $error("ID tag must be non-negative");
        end
    endgenerate

    typedef struct packed {
        logic                  valid;
        logic                  sgn;
        logic                  acc_en;
        logic                  last;
        logic [dout_WIDTH-1:0] prod;
    } beat_t;

    function automatic logic signed_add_ovf(input logic [dout_WIDTH-1:0] a,
                                            input logic [dout_WIDTH-1:0] b,
                                            input logic [dout_WIDTH-1:0] s);
        return (a[dout_WIDTH-1] == b[dout_WIDTH-1]) && (s[dout_WIDTH-1] != a[dout_WIDTH-1]);
    endfunction

    logic                    advance_s;
    logic signed [din0_WIDTH:0] a_ext_s;
    logic signed [din1_WIDTH:0] b_ext_s;
    logic signed [PW-1:0]    prod_full_s;
    logic [dout_WIDTH-1:0]   prod_s;
    beat_t                   head_s;
    beat_t                   tail_s;

    logic                    out_valid_r;
    logic [dout_WIDTH-1:0]   dout_r;
    logic [7:0]              acc_cnt_r;
    logic                    ovf_r;
    logic [dout_WIDTH-1:0]   acc_r;
    logic [7:0]              grp_cnt_r;
    logic                    grp_ovf_r;
    logic                    group_open_r;

    logic [dout_WIDTH-1:0]   base_s;
    logic [dout_WIDTH-1:0]   sum_s;
    logic                    carry_s;
    logic                    add_ovf_s;
    logic [7:0]              grp_cnt_next_s;
    logic                    grp_ovf_next_s;

    // The whole pipe moves only when the output register is free or draining.
    assign advance_s = ~(out_valid_r & ~out_ready);
    assign in_ready  = advance_s;

    // Operand extension and full-width product.
    always_comb begin
        a_ext_s     = {is_signed & din0[din0_WIDTH-1], din0};
        b_ext_s     = {is_signed & din1[din1_WIDTH-1], din1};
        prod_full_s = PW'(a_ext_s) * PW'(b_ext_s);
    end

    generate
        if (PW >= dout_WIDTH) begin : g_trunc
            assign prod_s = prod_full_s[dout_WIDTH-1:0];
        end else begin : g_extend
            assign prod_s = dout_WIDTH'(prod_full_s);
        end
    endgenerate

    // Beat entering stage 1.
    always_comb begin
        head_s.valid  = in_valid;
        head_s.sgn    = is_signed;
        head_s.acc_en = acc_en;
        head_s.last   = last;
        head_s.prod   = prod_s;
    end

    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign tail_s = head_s;
        end else begin : g_pipe
            beat_t stage_r [NUM_STAGE-1];

            // Intermediate product stages, frozen as a unit during a stall.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int i = 0; i < NUM_STAGE - 1; i++) begin
                        stage_r[i] <= '0;
                    end
                end else if (advance_s) begin
                    stage_r[0] <= head_s;
                    for (int i = 1; i < NUM_STAGE - 1; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign tail_s = stage_r[NUM_STAGE-2];
        end
    endgenerate

    // Accumulator add, overflow detect and saturating beat count.
    always_comb begin
        base_s             = group_open_r ? acc_r : {dout_WIDTH{1'b0}};
        {carry_s, sum_s}   = {1'b0, base_s} + {1'b0, tail_s.prod};
        if (tail_s.sgn) begin
            add_ovf_s = signed_add_ovf(base_s, tail_s.prod, sum_s);
        end else begin
            add_ovf_s = carry_s;
        end
        if (!group_open_r) begin
            grp_cnt_next_s = 8'd1;
        end else if (grp_cnt_r == 8'd255) begin
            grp_cnt_next_s = 8'd255;
        end else begin
            grp_cnt_next_s = grp_cnt_r + 8'd1;
        end
        grp_ovf_next_s = (group_open_r & grp_ovf_r) | add_ovf_s;
    end

    // Output register and open-group state.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_r  <= 1'b0;
            dout_r       <= '0;
            acc_cnt_r    <= 8'd0;
            ovf_r        <= 1'b0;
            acc_r        <= '0;
            grp_cnt_r    <= 8'd0;
            grp_ovf_r    <= 1'b0;
            group_open_r <= 1'b0;
        end else if (advance_s) begin
            if (tail_s.valid && !tail_s.acc_en) begin
                out_valid_r <= 1'b1;
                dout_r      <= tail_s.prod;
                acc_cnt_r   <= 8'd1;
                ovf_r       <= 1'b0;
            end else if (tail_s.valid && tail_s.last) begin
                out_valid_r  <= 1'b1;
                dout_r       <= sum_s;
                acc_cnt_r    <= grp_cnt_next_s;
                ovf_r        <= grp_ovf_next_s;
                acc_r        <= '0;
                grp_cnt_r    <= 8'd0;
                grp_ovf_r    <= 1'b0;
                group_open_r <= 1'b0;
            end else if (tail_s.valid) begin
                out_valid_r  <= 1'b0;
                acc_r        <= sum_s;
                grp_cnt_r    <= grp_cnt_next_s;
                grp_ovf_r    <= grp_ovf_next_s;
                group_open_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign dout      = dout_r;
    assign acc_cnt   = acc_cnt_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_dynamic_routing_mac_pipe.sv
// Bench for dynamic_routing_mac_pipe: 32-bit and 16-bit result instances driven in lockstep,
// hand-written vector table plus a reference model feeding per-instance result queues.
module tb_dynamic_routing_mac_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic [13:0] din0;
    logic [11:0] din1;
    logic        is_signed;
    logic        acc_en;
    logic        last;
    logic        out_ready;
    logic        rand_rdy;

    logic        in_ready32, out_valid32, ovf32;
    logic [31:0] dout32;
    logic [7:0]  cnt32;
    logic        in_ready16, out_valid16, ovf16;
    logic [15:0] dout16;
    logic [7:0]  cnt16;

    dynamic_routing_mac_pipe #(.ID(1), .NUM_STAGE(2), .din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(32)) dut32 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .din0(din0), .din1(din1), .is_signed(is_signed), .acc_en(acc_en), .last(last),
        .out_valid(out_valid32), .out_ready(out_ready), .dout(dout32), .acc_cnt(cnt32), .ovf(ovf32));

    dynamic_routing_mac_pipe #(.ID(2), .NUM_STAGE(2), .din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(16)) dut16 (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .din0(din0), .din1(din1), .is_signed(is_signed), .acc_en(acc_en), .last(last),
        .out_valid(out_valid16), .out_ready(out_ready), .dout(dout16), .acc_cnt(cnt16), .ovf(ovf16));

    typedef struct {
        logic [31:0] d;
        logic [7:0]  c;
        logic        o;
    } res_t;

    typedef struct {
        logic [13:0] d0;
        logic [11:0] d1;
        logic        sg;
        logic        ae;
        logic        la;
        logic        has_out;
        logic [31:0] d;
        logic [7:0]  c;
        logic        o;
    } vec_t;

    res_t q32[$];
    res_t q16[$];
    int   checks = 0;
    int   errors = 0;

    logic [63:0] m_acc  [2];
    logic [7:0]  m_cnt  [2];
    logic        m_ovf  [2];
    logic        m_open [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 64'd0; m_cnt[k] = 8'd0; m_ovf[k] = 1'b0; m_open[k] = 1'b0;
        end
        q32.delete();
        q16.delete();
    endtask

    // Reference model: k=0 is the 32-bit instance, k=1 the 16-bit one.
    task automatic model_step(input int k, input logic [13:0] d0, input logic [11:0] d1,
                              input logic sg, input logic ae, input logic la,
                              output logic produce, output res_t r);
        int w;
        longint a, b;
        logic [63:0] mask, p, base, full, sum;
        logic ao, no;
        logic [7:0] nc;
        w    = (k == 0) ? 32 : 16;
        a    = sg ? longint'($signed(d0)) : longint'(d0);
        b    = sg ? longint'($signed(d1)) : longint'(d1);
        mask = (64'd1 << w) - 64'd1;
        p    = (a * b) & mask;
        produce = 1'b0;
        r.d = 32'd0; r.c = 8'd0; r.o = 1'b0;
        if (!ae) begin
            produce = 1'b1; r.d = p[31:0]; r.c = 8'd1; r.o = 1'b0;
        end else begin
            base = m_open[k] ? m_acc[k] : 64'd0;
            full = base + p;
            sum  = full & mask;
            if (sg) ao = (base[w-1] == p[w-1]) && (sum[w-1] != p[w-1]);
            else    ao = (full >> w) != 64'd0;
            nc = !m_open[k] ? 8'd1 : ((m_cnt[k] == 8'd255) ? 8'd255 : m_cnt[k] + 8'd1);
            no = (m_open[k] && m_ovf[k]) || ao;
            if (la) begin
                produce = 1'b1; r.d = sum[31:0]; r.c = nc; r.o = no;
                m_open[k] = 1'b0; m_acc[k] = 64'd0; m_cnt[k] = 8'd0; m_ovf[k] = 1'b0;
            end else begin
                m_open[k] = 1'b1; m_acc[k] = sum; m_cnt[k] = nc; m_ovf[k] = no;
            end
        end
    endtask

    // Presents one beat, waits for acceptance and pushes expected results.
    task automatic drive_beat(input logic [13:0] d0, input logic [11:0] d1, input logic sg,
                              input logic ae, input logic la, input logic use_tab,
                              input res_t tab, input logic tab_out);
        bit   done = 0;
        logic p;
        res_t r;
        din0 = d0; din1 = d1; is_signed = sg; acc_en = ae; last = la; in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready32) begin
                model_step(1, d0, d1, sg, ae, la, p, r);
                if (p) q16.push_back(r);
                model_step(0, d0, d1, sg, ae, la, p, r);
                if (use_tab) begin
                    if (tab_out) q32.push_back(tab);
                end else if (p) begin
                    q32.push_back(r);
                end
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (q32.size() == 0 && q16.size() == 0) ok = 1;
        end
        @(posedge clk); #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q32.size(), q16.size());
        end
        chk("idle_out_valid32", out_valid32, 1'b0);
    endtask

    // Scoreboard pop for the 32-bit instance.
    always @(negedge clk) begin
        res_t e;
        if (rst_n === 1'b1 && out_valid32 && out_ready) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL out32_unexpected actual=%0h required=no_result", dout32);
            end else begin
                e = q32.pop_front();
                chk("dout32", dout32, e.d);
                chk("cnt32", cnt32, e.c);
                chk("ovf32", ovf32, e.o);
            end
        end
    end

    // Scoreboard pop for the 16-bit instance.
    always @(negedge clk) begin
        res_t e;
        if (rst_n === 1'b1 && out_valid16 && out_ready) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL out16_unexpected actual=%0h required=no_result", dout16);
            end else begin
                e = q16.pop_front();
                chk("dout16", dout16, e.d[15:0]);
                chk("cnt16", cnt16, e.c);
                chk("ovf16", ovf16, e.o);
            end
        end
    end

    // Random back-pressure while enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    vec_t tab [18];
    res_t t;

    initial begin
        tab[0]  = '{14'd16383, 12'd4095, 1'b0, 1'b0, 1'b0, 1'b1, 32'd67088385, 8'd1, 1'b0};
        tab[1]  = '{14'h3FFD,  12'd5,    1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF1, 8'd1, 1'b0};
        tab[2]  = '{14'd2,     12'd3,    1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        8'd0, 1'b0};
        tab[3]  = '{14'h3FFF,  12'd4,    1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        8'd0, 1'b0};
        tab[4]  = '{14'd5,     12'd5,    1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        8'd0, 1'b0};
        tab[5]  = '{14'd1,     12'd1,    1'b1, 1'b1, 1'b1, 1'b1, 32'd28,       8'd4, 1'b0};
        tab[6]  = '{14'd255,   12'd255,  1'b0, 1'b1, 1'b0, 1'b0, 32'd0,        8'd0, 1'b0};
        tab[7]  = '{14'd255,   12'd255,  1'b0, 1'b1, 1'b1, 1'b1, 32'd130050,   8'd2, 1'b0};
        tab[8]  = '{14'd1,     12'd1,    1'b0, 1'b1, 1'b0, 1'b0, 32'd0,        8'd0, 1'b0};
        tab[9]  = '{14'd2,     12'd2,    1'b0, 1'b1, 1'b1, 1'b1, 32'd5,        8'd2, 1'b0};
        tab[10] = '{14'd200,   12'd100,  1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        8'd0, 1'b0};
        tab[11] = '{14'd200,   12'd100,  1'b1, 1'b1, 1'b1, 1'b1, 32'd40000,    8'd2, 1'b0};
        tab[12] = '{14'd3,     12'd3,    1'b0, 1'b1, 1'b0, 1'b0, 32'd0,        8'd0, 1'b0};
        tab[13] = '{14'd7,     12'd7,    1'b0, 1'b0, 1'b0, 1'b1, 32'd49,       8'd1, 1'b0};
        tab[14] = '{14'd2,     12'd2,    1'b0, 1'b1, 1'b1, 1'b1, 32'd13,       8'd2, 1'b0};
        tab[15] = '{14'h2000,  12'h800,  1'b1, 1'b0, 1'b0, 1'b1, 32'h01000000, 8'd1, 1'b0};
        tab[16] = '{14'h3FFE,  12'd3,    1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        8'd0, 1'b0};
        tab[17] = '{14'd4,     12'd4,    1'b0, 1'b1, 1'b1, 1'b1, 32'd10,       8'd2, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; din0 = 14'd0; din1 = 12'd0;
        is_signed = 1'b0; acc_en = 1'b0; last = 1'b0; out_ready = 1'b1; rand_rdy = 1'b0;
        t.d = 32'd0; t.c = 8'd0; t.o = 1'b0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_dout", dout32, 32'd0);
        chk("rst_acc_cnt", cnt32, 8'd0);
        chk("rst_ovf", ovf32, 1'b0);
        chk("rst_in_ready", in_ready32, 1'b1);
        rst_n = 1'b1;
        chk("release_in_ready", in_ready32, 1'b1);

        for (int i = 0; i < 18; i++) begin
            t.d = tab[i].d; t.c = tab[i].c; t.o = tab[i].o;
            drive_beat(tab[i].d0, tab[i].d1, tab[i].sg, tab[i].ae, tab[i].la, 1'b1, t, tab[i].has_out);
        end
        drain();

        // acc_cnt saturates while the sum keeps growing
        t.d = 32'd300; t.c = 8'd255; t.o = 1'b0;
        for (int n = 0; n < 300; n++) begin
            drive_beat(14'd1, 12'd1, 1'b0, 1'b1, (n == 299), 1'b1, t, (n == 299));
        end
        drain();

        out_ready = 1'b0;
        fork
            begin
                for (int n = 0; n < 4; n++) begin
                    drive_beat(14'(n + 1), 12'(n + 2), 1'b0, 1'b0, 1'b0, 1'b0, t, 1'b0);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("stall_in_ready", in_ready32, 1'b0);
                chk("stall_out_valid", out_valid32, 1'b1);
                out_ready = 1'b1;
            end
        join
        drain();

        rand_rdy = 1'b1;
        for (int n = 0; n < 250; n++) begin
            drive_beat(14'($urandom), 12'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 3) == 0), 1'b0, t, 1'b0);
        end
        drain();

        for (int n = 0; n < 3; n++) begin
            drive_beat(14'd9, 12'd9, 1'b0, 1'b1, 1'b0, 1'b1, t, 1'b0);
        end
        rst_n = 1'b0;
        model_clear();
        #2;
        chk("midgrp_rst_out_valid", out_valid32, 1'b0);
        chk("midgrp_rst_dout", dout32, 32'd0);
        chk("midgrp_rst_cnt", cnt32, 8'd0);
        chk("midgrp_rst_ovf", ovf32, 1'b0);
        chk("midgrp_rst_in_ready", in_ready32, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midgrp_release_in_ready", in_ready32, 1'b1);
        drive_beat(14'd4, 12'd5, 1'b0, 1'b1, 1'b0, 1'b1, t, 1'b0);
        t.d = 32'd62; t.c = 8'd2; t.o = 1'b0;
        drive_beat(14'd6, 12'd7, 1'b0, 1'b1, 1'b1, 1'b1, t, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
